// File: rtl/xcvr_reconfig_arb.sv
// xcvr_reconfig_arb: round-robin share of one transceiver reconfig
// Avalon-MM port among PORTS masters, with a stall watchdog.
module xcvr_reconfig_arb #(
    parameter int PORTS      = 4,
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                        reconfig_clk,
    input  logic                        reconfig_rst,
    input  logic [PORTS*ADDR_WIDTH-1:0] s_address,
    input  logic [PORTS-1:0]            s_read,
    input  logic [PORTS-1:0]            s_write,
    input  logic [PORTS*DATA_WIDTH-1:0] s_writedata,
    output logic [PORTS*DATA_WIDTH-1:0] s_readdata,
    output logic [PORTS-1:0]            s_waitrequest,
    output logic [ADDR_WIDTH-1:0]       m_address,
    output logic                        m_read,
    output logic                        m_write,
    output logic [DATA_WIDTH-1:0]       m_writedata,
    input  logic [DATA_WIDTH-1:0]       m_readdata,
    input  logic                        m_waitrequest,
    output logic                        grant_valid,
    output logic [$clog2(PORTS)-1:0]    grant_index,
    output logic                        timeout_err
);
    localparam int IW = $clog2(PORTS);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_RESP
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic [DATA_WIDTH-1:0] r_m_wdata;
    logic                  r_m_rd;
    logic                  r_m_wr;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [PORTS-1:0]      r_swait;
    logic                  r_gvalid;
    logic [IW-1:0]         r_gidx;
    logic                  r_tout;
    logic [WW-1:0]         r_wdog;

    logic [PORTS-1:0]      w_req;
    logic                  w_any;
    logic [IW-1:0]         w_idx;
    logic [IW-1:0]         w_sel;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_sel_rd;
    logic                  w_sel_wr;

    assign w_req = s_read | s_write;
    assign w_any = |w_req;

    // Round-robin pick: first requester after the last grant, wrapping.
    always_comb begin
        w_sel = r_gidx;
        w_idx = r_gidx;
        for (int k = PORTS; k >= 1; k--) begin
            w_idx = IW'((int'(r_gidx) + k) % PORTS);
            if (w_req[w_idx]) w_sel = w_idx;
        end
    end

    assign w_sel_addr  = s_address[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_wdata = s_writedata[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_rd    = s_read[w_sel];
    assign w_sel_wr    = s_write[w_sel];

    // Grant / access / respond sequencer; every output is a register.
    always_ff @(posedge reconfig_clk or posedge reconfig_rst) begin
        if (reconfig_rst) begin
            r_state   <= ST_IDLE;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_rd    <= 1'b0;
            r_m_wr    <= 1'b0;
            r_rdata   <= '0;
            r_swait   <= '1;
            r_gvalid  <= 1'b0;
            r_gidx    <= IW'(PORTS - 1);
            r_tout    <= 1'b0;
            r_wdog    <= '0;
        end else begin
            r_tout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gidx    <= w_sel;
                        r_m_addr  <= w_sel_addr;
                        r_m_wdata <= w_sel_wdata;
                        // a read+write request is forwarded as a write
                        r_m_wr    <= w_sel_wr;
                        r_m_rd    <= w_sel_rd & ~w_sel_wr;
                        r_gvalid  <= 1'b1;
                        r_wdog    <= '0;
                        r_state   <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (!m_waitrequest) begin
                        if (r_m_rd) r_rdata <= m_readdata;
                        r_m_rd          <= 1'b0;
                        r_m_wr          <= 1'b0;
                        r_wdog          <= '0;
                        r_swait[r_gidx] <= 1'b0;
                        r_state         <= ST_RESP;
                    end else if (r_wdog == WD_LAST) begin
                        r_rdata         <= '1;
                        r_tout          <= 1'b1;
                        r_m_rd          <= 1'b0;
                        r_m_wr          <= 1'b0;
                        r_wdog          <= '0;
                        r_swait[r_gidx] <= 1'b0;
                        r_state         <= ST_RESP;
                    end else begin
                        r_wdog <= r_wdog + WW'(1);
                    end
                end
                ST_RESP: begin
                    r_swait  <= '1;
                    r_gvalid <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_readdata    = {PORTS{r_rdata}};
    assign s_waitrequest = r_swait;
    assign m_address     = r_m_addr;
    assign m_read        = r_m_rd;
    assign m_write       = r_m_wr;
    assign m_writedata   = r_m_wdata;
    assign grant_valid   = r_gvalid;
    assign grant_index   = r_gidx;
    assign timeout_err   = r_tout;

endmodule

// File: tb/tb_xcvr_reconfig_arb.sv
// tb_xcvr_reconfig_arb: random masters and slave against a
// cycle-level transaction model of the arbiter.
module tb_xcvr_reconfig_arb;
    localparam int P  = 4;
    localparam int AW = 19;
    localparam int DW = 8;
    localparam int TO = 16;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [P*AW-1:0] s_address;
    logic [P-1:0]    s_read;
    logic [P-1:0]    s_write;
    logic [P*DW-1:0] s_writedata;
    logic [P*DW-1:0] s_readdata;
    logic [P-1:0]    s_waitrequest;
    logic [AW-1:0]   m_address;
    logic            m_read;
    logic            m_write;
    logic [DW-1:0]   m_writedata;
    logic [DW-1:0]   m_readdata;
    logic            m_waitrequest;
    logic            grant_valid;
    logic [IW-1:0]   grant_index;
    logic            timeout_err;

    xcvr_reconfig_arb #(
        .PORTS(P), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .reconfig_clk (clk),
        .reconfig_rst (rst),
        .s_address    (s_address),
        .s_read       (s_read),
        .s_write      (s_write),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .s_waitrequest(s_waitrequest),
        .m_address    (m_address),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .m_waitrequest(m_waitrequest),
        .grant_valid  (grant_valid),
        .grant_index  (grant_index),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // master request state
    logic          rq_rd   [P];
    logic          rq_wr   [P];
    logic [AW-1:0] rq_addr [P];
    logic [DW-1:0] rq_data [P];

    always_comb begin
        s_read      = '0;
        s_write     = '0;
        s_address   = '0;
        s_writedata = '0;
        for (int p = 0; p < P; p++) begin
            s_read[p]               = rq_rd[p];
            s_write[p]              = rq_wr[p];
            s_address[p*AW +: AW]   = rq_addr[p];
            s_writedata[p*DW +: DW] = rq_data[p];
        end
    end

    // inputs as seen by the DUT at each rising edge
    logic          rst_s = 1'b1;
    logic          w_s   = 1'b1;
    logic [DW-1:0] rd_s  = '0;
    logic          rd_sv   [P];
    logic          wr_sv   [P];
    logic [AW-1:0] addr_sv [P];
    logic [DW-1:0] data_sv [P];

    always @(posedge clk) begin
        rst_s <= rst;
        w_s   <= m_waitrequest;
        rd_s  <= m_readdata;
        for (int p = 0; p < P; p++) begin
            rd_sv[p]   <= rq_rd[p];
            wr_sv[p]   <= rq_wr[p];
            addr_sv[p] <= rq_addr[p];
            data_sv[p] <= rq_data[p];
        end
    end

    // reference model: 0 idle, 1 access on slave, 2 response
    int            ph = 0;
    int            gp = 0;
    int            last = P - 1;
    int            k = 0;
    int            stall = 0;
    logic          to_flag = 1'b0;
    logic [DW-1:0] exp_rd = '0;
    logic          e_rd = 1'b0;
    logic          e_wr = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_data = '0;

    int  forced_stall = -1;
    int  forced_data = -1;
    bit  auto_rq = 1'b0;
    bit  rand_rq = 1'b0;
    int  gq[$];
    int  cyc = 0;
    int  ack_cyc = 0;
    int  rdc = 0;
    int  wrc = 0;
    int  to_cnt = 0;
    int  swl_cnt = 0;
    logic [DW-1:0] resp_data = '0;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic new_req(input int p);
        int r;
        r = int'($urandom_range(0, 3));
        rq_rd[p]   = (r != 1);
        rq_wr[p]   = (r == 1) || (r == 2);
        rq_addr[p] = AW'($urandom);
        rq_data[p] = DW'($urandom);
    endtask

    function automatic bit any_req();
        for (int p = 0; p < P; p++)
            if (rq_rd[p] || rq_wr[p]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step();
        logic [P-1:0] exp_sw;
        int pick;
        @(negedge clk);
        cyc++;
        if (rst_s) begin
            ph = 0;
        end else begin
            case (ph)
                0: begin
                    pick = -1;
                    for (int o = 1; o <= P; o++) begin
                        int q;
                        q = (last + o) % P;
                        if (pick < 0 && (rd_sv[q] || wr_sv[q])) pick = q;
                    end
                    if (pick >= 0) begin
                        gp      = pick;
                        last    = pick;
                        e_wr    = wr_sv[gp];
                        e_rd    = rd_sv[gp] && !wr_sv[gp];
                        e_addr  = addr_sv[gp];
                        e_data  = data_sv[gp];
                        k       = 0;
                        to_flag = 1'b0;
                        ph      = 1;
                        if (forced_stall >= 0) stall = forced_stall;
                        else if ($urandom_range(0, 9) == 0) stall = TO + 4;
                        else stall = int'($urandom_range(0, 4));
                        gq.push_back(int'(grant_index));
                    end
                end
                1: begin
                    if (!w_s) begin
                        if (e_rd) exp_rd = rd_s;
                        ph = 2;
                    end else if (k == TO - 1) begin
                        exp_rd  = '1;
                        to_flag = 1'b1;
                        ph      = 2;
                    end else begin
                        k++;
                    end
                end
                default: ph = 0;
            endcase
        end

        exp_sw = '1;
        if (ph == 2) exp_sw[gp] = 1'b0;
        chk("m_read", m_read, ph == 1 && e_rd);
        chk("m_write", m_write, ph == 1 && e_wr);
        if (ph == 1) begin
            chk("m_address", m_address, e_addr);
            chk("m_writedata", m_writedata, e_data);
        end
        chk("grant_valid", grant_valid, ph != 0);
        chk("grant_index", grant_index, last);
        chk("s_waitrequest", s_waitrequest, exp_sw);
        chk("s_readdata", s_readdata, {P{exp_rd}});
        chk("timeout_err", timeout_err, ph == 2 && to_flag);

        if (m_read) rdc++;
        if (m_write) wrc++;
        if (timeout_err) to_cnt++;
        if (s_waitrequest != '1) begin
            swl_cnt++;
            ack_cyc   = cyc;
            resp_data = s_readdata[DW-1:0];
        end

        if (ph == 1) begin
            m_waitrequest = (k < stall);
            m_readdata = (forced_data >= 0) ? DW'(forced_data) : DW'($urandom);
        end else begin
            m_waitrequest = 1'($urandom);
            m_readdata    = DW'($urandom);
        end
        if (ph == 2) begin
            rq_rd[gp] = 1'b0;
            rq_wr[gp] = 1'b0;
            if (auto_rq) new_req(gp);
        end
        if (rand_rq)
            for (int p = 0; p < P; p++)
                if (!rq_rd[p] && !rq_wr[p] && $urandom_range(0, 3) == 0)
                    new_req(p);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((any_req() || ph != 0) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) chk("drain_budget", n, 299);
    endtask

    task automatic clr_obs();
        rdc = 0;
        wrc = 0;
        to_cnt = 0;
        swl_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int n;
        int fo [5];
        fo = '{0, 1, 2, 3, 0};
        for (int p = 0; p < P; p++) begin
            rq_rd[p]   = 1'b0;
            rq_wr[p]   = 1'b0;
            rq_addr[p] = '0;
            rq_data[p] = '0;
        end
        m_waitrequest = 1'b1;
        m_readdata    = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // all ports requesting back to back, zero-wait slave
        forced_stall = 0;
        auto_rq = 1'b1;
        for (int p = 0; p < P; p++) new_req(p);
        repeat (16) step();
        auto_rq = 1'b0;
        drain();
        if (gq.size() < 5) chk("fair_count", gq.size(), 5);
        else for (int i = 0; i < 5; i++) chk("fair_order", gq[i], fo[i]);

        // single write on port 2
        clr_obs();
        forced_stall = 0;
        rq_wr[2] = 1'b1;
        rq_addr[2] = 19'h40143;
        rq_data[2] = 8'h80;
        c0 = cyc;
        drain();
        chk("wr_cycles", wrc, 1);
        chk("wr_ack_count", swl_cnt, 1);
        chk("wr_ack_latency", ack_cyc - c0, 2);

        // read on port 0 with a 5-cycle stall
        clr_obs();
        forced_stall = 5;
        forced_data = 8'h80;
        rq_rd[0] = 1'b1;
        rq_addr[0] = 19'h00207;
        c0 = cyc;
        drain();
        chk("rd_cycles", rdc, 6);
        chk("rd_ack_count", swl_cnt, 1);
        chk("rd_data", resp_data, 8'h80);
        chk("rd_ack_latency", ack_cyc - c0, 7);

        // slave never answers a port 1 read
        clr_obs();
        forced_stall = 1000;
        forced_data = -1;
        rq_rd[1] = 1'b1;
        rq_addr[1] = AW'($urandom);
        drain();
        chk("to_cycles", rdc, 16);
        chk("to_pulses", to_cnt, 1);
        chk("to_data", resp_data, 8'hFF);
        chk("to_ack_count", swl_cnt, 1);

        // read and write together on port 3
        clr_obs();
        forced_stall = 0;
        rq_rd[3] = 1'b1;
        rq_wr[3] = 1'b1;
        rq_addr[3] = AW'($urandom);
        rq_data[3] = DW'($urandom);
        drain();
        chk("dual_rd_cycles", rdc, 0);
        chk("dual_wr_cycles", wrc, 1);
        chk("dual_ack_count", swl_cnt, 1);

        // reset in the middle of a stalled read
        forced_stall = 8;
        rq_rd[2] = 1'b1;
        rq_wr[2] = 1'b0;
        rq_addr[2] = AW'($urandom);
        n = 0;
        while (!(ph == 1 && k == 2) && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("rst_setup_budget", n, 49);
        new_req(1);
        new_req(3);
        rst = 1'b1;
        #1;
        chk("rst_m_read", m_read, 1'b0);
        chk("rst_m_write", m_write, 1'b0);
        chk("rst_s_waitrequest", s_waitrequest, 4'hF);
        chk("rst_grant_valid", grant_valid, 1'b0);
        chk("rst_grant_index", grant_index, P - 1);
        last = P - 1;
        exp_rd = '0;
        to_flag = 1'b0;
        step();
        step();
        rst = 1'b0;
        gq.delete();
        forced_stall = 0;
        drain();
        chk("post_rst_grant", gq.size() > 0 ? gq[0] : -1, 1);

        // random traffic
        forced_stall = -1;
        rand_rq = 1'b1;
        repeat (600) step();
        rand_rq = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/xcvr_reconfig_arb.md
Name: xcvr_reconfig_arb

Overview:
Round-robin arbiter that lets PORTS independent transceiver-control masters share one transceiver reconfiguration Avalon-MM port. Examples of such masters are per-channel PMA-load/adaptation sequencers or a host bridge. It sits directly downstream of the xcvr_ctrl sequencers and directly upstream of the hard transceiver reconfig interface. Every master-side output is registered. A watchdog aborts any slave access that stalls.

Parameters:
PORTS, 4, number of upstream master ports (2..16)
ADDR_WIDTH, 19, reconfig address width
DATA_WIDTH, 8, reconfig data width
TIMEOUT, 1024, max cycles m_waitrequest may stay high before abort (>=2)

Ports:
reconfig_clk  in  1  clock; all logic in this single domain
reconfig_rst  in  1  reset, asynchronous assert, active-high
s_address  in  PORTS*ADDR_WIDTH  per-port address; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
s_read  in  PORTS  per-port read request
s_write  in  PORTS  per-port write request
s_writedata  in  PORTS*DATA_WIDTH  per-port write data
s_readdata  out  PORTS*DATA_WIDTH  captured read data, replicated to every port
s_waitrequest  out  PORTS  per-port waitrequest; low for exactly one cycle at completion
m_address  out  ADDR_WIDTH  to transceiver reconfig
m_read  out  1  to transceiver reconfig
m_write  out  1  to transceiver reconfig
m_writedata  out  DATA_WIDTH  to transceiver reconfig
m_readdata  in  DATA_WIDTH  from transceiver reconfig
m_waitrequest  in  1  from transceiver reconfig
grant_valid  out  1  high in ACTIVE and RESP
grant_index  out  $clog2(PORTS)  currently or last granted port
timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset values (reconfig_rst high, applied asynchronously):
  - state=IDLE; m_read=m_write=0; m_address=0; m_writedata=0.
  - s_waitrequest=all ones; s_readdata=0.
  - grant_valid=0; grant_index=PORTS-1, so port 0 has highest priority first; timeout_err=0; watchdog=0.
- Upstream protocol: a master holds read/write, address and writedata while its s_waitrequest is high. It samples s_readdata in the cycle its s_waitrequest is low, then drops the request.
- IDLE:
  - Request vector req[i] = s_read[i] | s_write[i].
  - If any req bit is set, select the first set bit searching from grant_index+1 upward, wrapping modulo PORTS.
  - Register grant_index and the selected port's address, writedata, read and write onto the m_* registers; set grant_valid; go to ACTIVE.
  - Latency is 1 cycle from request to m_* asserted.
  - If both s_read and s_write are set on the selected port, forward the write only (m_read=0).
- ACTIVE:
  - Hold all m_* outputs and increment the watchdog.
  - Cycle with m_waitrequest=0: capture m_readdata into the s_readdata register (reads only; writes leave it unchanged). Clear m_read/m_write and the watchdog. Go to RESP.
  - Watchdog reaching TIMEOUT-1 with m_waitrequest still high: clear m_read/m_write, load s_readdata with all ones, pulse timeout_err, go to RESP.
- RESP (1 cycle):
  - s_waitrequest[grant_index]=0; all other bits remain 1.
  - Next state IDLE; grant_valid drops entering IDLE.
  - Minimum transaction is 3 cycles (IDLE grant, ACTIVE, RESP).
- Fairness: the port just served has lowest priority at the next arbitration. With all PORTS requesting continuously, grants rotate i, i+1, ...
- Non-granted ports always see s_waitrequest=1 and their requests are held off indefinitely, with no side effects.
- A request withdrawn by its master while pending or active violates the protocol. An already-issued m_* access still completes normally and RESP still occurs.
- Reset mid-transaction: m_read/m_write drop immediately. The slave-side access is abandoned and no RESP is generated.
- No combinational path from any s_* input to any m_* output, or from m_waitrequest to s_waitrequest.

Test Plan:
- Single write: port 2 writes addr 0x40143 data 0x80; slave waitrequest low on the first cycle -> m_write high for 1 cycle with m_address=0x40143, m_writedata=0x80; s_waitrequest[2] low 2 cycles after the request; other bits stay 1.
- Read with stall: port 0 reads 0x207; slave holds waitrequest 5 cycles, then returns 0x80 -> m_read high 6 cycles; s_waitrequest[0] low exactly 1 cycle with s_readdata=0x80.
- Fairness: ports 0-3 request continuously from reset -> grant order 0,1,2,3,0; each transaction takes 3 cycles with zero-wait slave.
- Timeout: TIMEOUT=16; slave never drops waitrequest on a port 1 read -> m_read drops after 16 ACTIVE cycles; timeout_err pulses once; s_readdata=0xFF; s_waitrequest[1] low for 1 cycle.
- Reset mid-access: assert reconfig_rst while ACTIVE -> m_read/m_write drop with no clock edge; all s_waitrequest=1. After release, the next grant goes to the lowest-numbered requester.
- Dual command: port 3 asserts read and write together -> only m_write asserted; completion handshake as for a normal write.
